csr_dec_mul_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one pipelined 14x14 signed multiplier (csr_dec_mul_mul_14s_14s_14_4_1, 3 ce-gated register stages) among NUM_REQ requesters inside the CSR decoder.
- Accepts operand pairs over valid/ready, drives the multiplier's ce/din0/din1, and tags each issue with the requester ID in a matched shift pipeline.
- Returns the 14-bit truncated product with its ID over a single valid/ready result port; backpressure is applied by freezing the multiplier ce.

---
 rtl/csr_dec_mul_arb_pkg.sv | 30 +++
 rtl/csr_dec_rr_arb.sv | 38 +++
 rtl/csr_dec_mul_arb.sv | 129 ++++++++++++
 tb/tb_csr_dec_mul_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_dec_mul_arb_pkg.sv
// Shared types and helpers for the CSR-decoder multiplier arbiter.
// Widths are sized for the largest supported configuration (8 requesters).
package csr_dec_mul_arb_pkg;

  localparam int unsigned DW          = 14;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned MAX_ID_W    = 3;

  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  // One-hot pick of the first valid slot at or above ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_ID_W-1:0] ptr,
                                                 input int unsigned         n);
    logic [MAX_REQ-1:0] gnt;
    int unsigned        idx;
    gnt = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && gnt == '0 && valid[MAX_ID_W'(idx)]) gnt[MAX_ID_W'(idx)] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/csr_dec_rr_arb.sv
// Generic round-robin picker with its own pointer register; the pointer moves
// one past the winner on every granted cycle.
module csr_dec_rr_arb
  import csr_dec_mul_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_any,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr_q), N);
    gnt_any = en & (|pick);
    gnt     = en ? pick[N-1:0] : '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) gnt_idx = IW'(i);
    end
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/csr_dec_mul_arb.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters.
// Define CSR_DEC_MUL_ARB_STATS_EN to add saturating grant/stall counters.
module csr_dec_mul_arb
  import csr_dec_mul_arb_pkg::tag_t, csr_dec_mul_arb_pkg::NUM_REQ_DEF,
         csr_dec_mul_arb_pkg::MUL_LAT_DEF, csr_dec_mul_arb_pkg::MAX_ID_W;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DW      = csr_dec_mul_arb_pkg::DW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  mul_ce,
  output logic [DW-1:0]         mul_din0,
  output logic [DW-1:0]         mul_din1,
  input  logic [DW-1:0]         mul_dout,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [DW-1:0]         res_data,
  input  logic                  res_ready,
  output logic                  busy
`ifdef CSR_DEC_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grant,
  output logic [15:0]           stat_stall
`endif
);

  logic               stall;
  logic               arb_en;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [DW-1:0]      din0_q, din0_d, din1_q, din1_d;
  tag_t               tag_q [MUL_LAT];
  tag_t               tag_d [MUL_LAT];

  // Only a valid head can stall, so bubbles at the head always drain.
  assign stall  = res_valid & ~res_ready;
  assign mul_ce = ~stall;
  assign arb_en = ~stall & ~flush & reset_n;

  csr_dec_rr_arb #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    din0_d = gnt_any ? req_a[32'(gnt_idx)*DW +: DW] : din0_q;
    din1_d = gnt_any ? req_b[32'(gnt_idx)*DW +: DW] : din1_q;
    tag_d  = tag_q;
    // Flush wins over a stall: tags clear even while the multiplier is frozen.
    if (flush) begin
      for (int unsigned k = 0; k < MUL_LAT; k++) tag_d[k].v = 1'b0;
    end else if (mul_ce) begin
      tag_d[0].v  = gnt_any;
      tag_d[0].id = MAX_ID_W'(gnt_idx);
      for (int unsigned k = 1; k < MUL_LAT; k++) tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < MUL_LAT; k++) busy |= tag_q[k].v;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din0_q <= '0;
      din1_q <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
    end else begin
      din0_q <= din0_d;
      din1_q <= din1_d;
      tag_q  <= tag_d;
    end
  end

  assign req_ready = gnt;
  assign mul_din0  = din0_d;
  assign mul_din1  = din1_d;
  assign res_valid = tag_q[MUL_LAT-1].v;
  assign res_id    = ID_W'(tag_q[MUL_LAT-1].id);
  assign res_data  = mul_dout;

`ifdef CSR_DEC_MUL_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] grant_cnt_d [NUM_REQ];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (gnt[i] && grant_cnt_q[i] != '1) grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) stat_grant[i*16 +: 16] = grant_cnt_q[i];
    stat_stall = stall_cnt_q;
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_csr_dec_mul_arb.sv
// Directed bench for csr_dec_mul_arb with a behavioural 3-stage ce-gated
// signed multiplier standing in for the shared multiplier core.
module tb_csr_dec_mul_arb;

  localparam int unsigned NR  = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned LAT = 3;
  localparam int unsigned W   = 14;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_a, req_b;
  logic [NR-1:0]     req_ready;
  logic              mul_ce;
  logic [W-1:0]      mul_din0, mul_din1, mul_dout;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;
  logic              res_ready;
  logic              busy;
`ifdef CSR_DEC_MUL_ARB_STATS_EN
  logic [NR*16-1:0]  stat_grant;
  logic [15:0]       stat_stall;
`endif

  always #5 clk = ~clk;

  csr_dec_mul_arb #(.NUM_REQ(NR), .ID_W(IDW), .MUL_LAT(LAT), .DW(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef CSR_DEC_MUL_ARB_STATS_EN
    ,
    .stat_grant(stat_grant),
    .stat_stall(stat_stall)
`endif
  );

  // Multiplier model: low W bits of the signed product, LAT ce-gated stages.
  logic signed [2*W-1:0] prod;
  logic [W-1:0]          m_q [LAT];
  assign prod     = $signed(mul_din0) * $signed(mul_din1);
  assign mul_dout = m_q[LAT-1];
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      m_q[0] <= prod[W-1:0];
      for (int unsigned k = 1; k < LAT; k++) m_q[k] <= m_q[k-1];
    end
  end

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_slots(input int unsigned b);
    for (int unsigned i = 0; i < NR; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(b);
    end
  endtask

  typedef struct {
    int unsigned rq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vt [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NR-1:0] eg;
    int unsigned   k;

    vt[0] = '{rq: 0, a: 14'h0003, b: 14'h3FFB, exp: 14'h3FF1};
    vt[1] = '{rq: 1, a: 14'h007F, b: 14'h00C8, exp: 14'h2338};
    vt[2] = '{rq: 2, a: 14'h3FFF, b: 14'h3FFF, exp: 14'h0001};
    vt[3] = '{rq: 3, a: 14'h1FFF, b: 14'h0002, exp: 14'h3FFE};
    vt[4] = '{rq: 2, a: 14'h2000, b: 14'h3FFF, exp: 14'h2000};
    vt[5] = '{rq: 1, a: 14'h0064, b: 14'h0064, exp: 14'h2710};
    vt[6] = '{rq: 3, a: 14'h0000, b: 14'h04D2, exp: 14'h0000};

    reset_n = 1'b0; flush = 1'b0; req_valid = '1; res_ready = 1'b1;
    req_a = '0; req_b = '0;
    #3;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk); #2; reset_n = 1'b1;

    // Single-requester vectors; latency and mux selection checked per entry.
    for (int unsigned i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      req_a = {NR{14'h0155}};
      req_b = {NR{14'h02AA}};
      req_a[vt[i].rq*W +: W] = vt[i].a;
      req_b[vt[i].rq*W +: W] = vt[i].b;
      req_valid = NR'(1) << vt[i].rq;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), req_ready, NR'(1) << vt[i].rq);
      for (int unsigned c = 1; c <= 3; c++) begin
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk($sformatf("tbl%0d_valid_c%0d", i, c), res_valid, 32'(c == 3));
        if (c == 1) chk($sformatf("tbl%0d_busy", i), busy, 1);
      end
      chk($sformatf("tbl%0d_id", i), res_id, vt[i].rq);
      chk($sformatf("tbl%0d_data", i), res_data, vt[i].exp);
    end

    // Continuous requests from all slots: strict rotation, one result per cycle.
    set_slots(10);
    for (int unsigned c = 0; c < 12; c++) begin
      @(posedge clk); #1; req_valid = (c < 8) ? '1 : '0;
      @(negedge clk);
      eg = (c < 8) ? NR'(1) << (c % 4) : '0;
      chk($sformatf("rr_grant_c%0d", c), req_ready, eg);
      chk($sformatf("rr_valid_c%0d", c), res_valid, 32'(c >= 3 && c < 11));
      if (c >= 3 && c < 11) begin
        k = (c - 3) % 4;
        chk($sformatf("rr_id_c%0d", c), res_id, k);
        chk($sformatf("rr_data_c%0d", c), res_data, (k + 1) * 10);
      end
    end

    // Backpressure: 5 stalled cycles, then drain.
    for (int unsigned c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 9) ? '1 : '0;
      res_ready = !(c >= 4 && c <= 8);
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("bp_grant_c%0d", c), req_ready, NR'(1) << c);
        chk($sformatf("bp_ce_c%0d", c), mul_ce, 1);
      end else begin
        chk($sformatf("bp_grant_c%0d", c), req_ready, 0);
      end
      if (c == 3) begin
        chk("bp_id_c3", res_id, 0);
        chk("bp_data_c3", res_data, 10);
      end
      if (c >= 4 && c <= 8) begin
        chk($sformatf("bp_ce_c%0d", c), mul_ce, 0);
        chk($sformatf("bp_valid_c%0d", c), res_valid, 1);
        chk($sformatf("bp_id_c%0d", c), res_id, 1);
        chk($sformatf("bp_data_c%0d", c), res_data, 20);
      end
      if (c >= 9 && c <= 11) begin
        chk($sformatf("bp_valid_c%0d", c), res_valid, 1);
        chk($sformatf("bp_id_c%0d", c), res_id, c - 8);
        chk($sformatf("bp_data_c%0d", c), res_data, (c - 7) * 10);
      end
      if (c == 12) begin
        chk("bp_valid_c12", res_valid, 0);
        chk("bp_busy_c12", busy, 0);
      end
    end
    res_ready = 1'b1;

    // Flush with three in flight, then one fresh request.
    for (int unsigned c = 0; c < 3; c++) begin
      @(posedge clk); #1; req_valid = 4'b0111;
      @(negedge clk);
      chk($sformatf("fl_grant_c%0d", c), req_ready, NR'(1) << c);
    end
    @(posedge clk); #1; req_valid = '1; flush = 1'b1;
    @(negedge clk);
    chk("fl_blocked", req_ready, 0);
    chk("fl_head_valid", res_valid, 1);
    chk("fl_head_id", res_id, 0);
    chk("fl_busy_before", busy, 1);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 4'b0010;
    req_a[1*W +: W] = 14'h3FF9; req_b[1*W +: W] = 14'h0009;
    @(negedge clk);
    chk("fl_busy_after", busy, 0);
    chk("fl_valid_after", res_valid, 0);
    chk("fl_new_grant", req_ready, 4'b0010);
    for (int unsigned c = 1; c <= 3; c++) begin
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      chk($sformatf("fl_new_valid_c%0d", c), res_valid, 32'(c == 3));
    end
    chk("fl_new_id", res_id, 1);
    chk("fl_new_data", res_data, 14'h3FC1);

    // Async reset mid-burst; pointer must restart at slot 0.
    set_slots(10);
    for (int unsigned c = 0; c < 4; c++) begin
      @(posedge clk); #1; req_valid = '1;
      @(negedge clk);
      chk($sformatf("ar_grant_c%0d", c), req_ready, NR'(1) << ((c + 2) % 4));
    end
    chk("ar_pre_valid", res_valid, 1);
    #2; reset_n = 1'b0; #1;
    chk("ar_res_valid", res_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_req_ready", req_ready, 0);
    @(posedge clk); #1; req_valid = 4'b1001;
    @(negedge clk); #2; reset_n = 1'b1; #1;
    chk("ar_first_grant", req_ready, 4'b0001);
    for (int unsigned c = 1; c <= 3; c++) begin
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      chk($sformatf("ar_valid_c%0d", c), res_valid, 32'(c == 3));
    end
    chk("ar_id", res_id, 0);
    chk("ar_data", res_data, 10);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
